// File: rtl/angle_cmd_ctrl_pkg.sv
// Shared encodings, reply constants and frame field positions for the
// UART angle command path.
package angle_cmd_ctrl_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_WAIT_LO = 3'd1;
  localparam logic [2:0] ST_CHECK   = 3'd2;
  localparam logic [2:0] ST_APPLY   = 3'd3;
  localparam logic [2:0] ST_REPLY   = 3'd4;

  localparam logic [1:0] TX_IDLE  = 2'd0;
  localparam logic [1:0] TX_REPLY = 2'd1;
  localparam logic [1:0] TX_WAIT  = 2'd2;

  localparam logic [3:0] ACK_HI      = 4'hA;
  localparam logic [3:0] NAK_HI      = 4'hE;
  localparam logic [3:0] NAK_PARITY  = 4'd1;
  localparam logic [3:0] NAK_TIMEOUT = 4'd2;
  localparam logic [3:0] NAK_RANGE   = 4'd3;

  localparam logic [3:0] BCAST_ID_DEFAULT = 4'hF;

  localparam int B1_ADDR_MSB = 7;
  localparam int B1_ADDR_LSB = 4;
  localparam int B1_ANG_MSB  = 3;
  localparam int B1_ANG_LSB  = 0;

  typedef struct packed {
    logic [7:0] data;
    logic       par;
  } rx_byte_t;

  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [1:0] inc);
    logic [8:0] s;
    s = {1'b0, a} + {7'd0, inc};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

endpackage

// File: rtl/angle_cmd_ctrl_reply_sender.sv
// One-byte reply handshake with uart_tx: waits for an idle transmitter,
// holds start_tx until busy is seen, then waits for the byte to finish.
module angle_cmd_ctrl_reply_sender
  import angle_cmd_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       req,
  input  logic [7:0] req_byte,
  input  logic       tx_busy,
  output logic [7:0] data_to_tx,
  output logic       start_tx,
  output logic       done
);

  logic [1:0] st_q, st_d;
  logic [7:0] data_q, data_d;
  logic       start_q, start_d;
  logic       done_q, done_d;

  always_comb begin
    st_d    = st_q;
    data_d  = data_q;
    start_d = start_q;
    done_d  = 1'b0;
    case (st_q)
      TX_IDLE: begin
        if (req) begin
          data_d = req_byte;
          st_d   = TX_REPLY;
        end
      end
      TX_REPLY: begin
        if (start_q && tx_busy) begin
          start_d = 1'b0;
          st_d    = TX_WAIT;
        end else if (!tx_busy) begin
          start_d = 1'b1;
        end
      end
      TX_WAIT: begin
        if (!tx_busy) begin
          st_d   = TX_IDLE;
          done_d = 1'b1;
        end
      end
      default: st_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q    <= TX_IDLE;
      data_q  <= 8'd0;
      start_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      st_q    <= st_d;
      data_q  <= data_d;
      start_q <= start_d;
      done_q  <= done_d;
    end
  end

  assign data_to_tx = data_q;
  assign start_tx   = start_q;
  assign done       = done_q;

endmodule

// File: rtl/angle_cmd_ctrl.sv
// Framing FSM for the UART angle command: assembles two bytes, checks address,
// parity, range and inter-byte timeout, loads the angle and requests a reply.
module angle_cmd_ctrl
  import angle_cmd_ctrl_pkg::*;
#(
  parameter logic [3:0]  MODULE_ID      = 4'd1,
  parameter logic [3:0]  BCAST_ID       = BCAST_ID_DEFAULT,
  parameter logic [11:0] ANGLE_MAX      = 12'd3599,
  parameter int          TIMEOUT_CYCLES = 48000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  data_received,
  input  logic        rx_done,
  input  logic        parity_error,
  input  logic        tx_busy,
  output logic [7:0]  data_to_tx,
  output logic        start_tx,
  output logic [11:0] angle,
  output logic        angle_load,
  output logic [7:0]  err_cnt,
  output logic        link_err
);

  localparam int               TMR_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  logic             rx_prev_q, rx_prev_d;
  logic             evt_q, evt_d;
  rx_byte_t         evt_byte_q, evt_byte_d;
  rx_byte_t         hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic [2:0]       state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [3:0]       hi_q, hi_d;
  logic [7:0]       lo_q, lo_d;
  logic             bcast_q, bcast_d;
  logic [11:0]      angle_q, angle_d;
  logic             angle_load_q, angle_load_d;
  logic [7:0]       err_cnt_q, err_cnt_d;
  logic             link_err_q, link_err_d;
  logic             req_q, req_d;
  logic [7:0]       reply_q, reply_d;

  logic             reply_done;
  logic             accepting;
  logic             in_valid;
  rx_byte_t         in_byte;
  logic [3:0]       in_addr;
  logic [11:0]      frame_val;
  logic             ovw_err;
  logic             nak_hit;
  logic [3:0]       nak_code;
  logic             nak_bc;

  // A long rx_done strobe yields a single event on its rising edge.
  always_comb begin
    rx_prev_d  = rx_done;
    evt_d      = rx_done & ~rx_prev_q;
    evt_byte_d = evt_byte_q;
    if (evt_d) evt_byte_d = '{data: data_received, par: parity_error};
  end

  // The holding register is older than a fresh event, so it is consumed first.
  always_comb begin
    accepting   = (state_q == ST_IDLE) || (state_q == ST_WAIT_LO);
    in_valid    = accepting && (hold_full_q || evt_q);
    in_byte     = hold_full_q ? hold_q : evt_byte_q;
    in_addr     = in_byte.data[B1_ADDR_MSB:B1_ADDR_LSB];
    frame_val   = {hi_q, lo_q};
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    ovw_err     = 1'b0;
    if (accepting) begin
      if (hold_full_q) begin
        hold_full_d = evt_q;
        if (evt_q) hold_d = evt_byte_q;
      end
    end else if (evt_q) begin
      hold_d      = evt_byte_q;
      hold_full_d = 1'b1;
      ovw_err     = hold_full_q;
    end
  end

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    bcast_d      = bcast_q;
    angle_d      = angle_q;
    angle_load_d = 1'b0;
    link_err_d   = link_err_q;
    req_d        = 1'b0;
    reply_d      = reply_q;
    nak_hit      = 1'b0;
    nak_code     = NAK_PARITY;
    nak_bc       = bcast_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          if (in_byte.par) begin
            nak_hit = 1'b1;
            nak_bc  = 1'b0;
          end else if (in_addr == MODULE_ID || in_addr == BCAST_ID) begin
            hi_d    = in_byte.data[B1_ANG_MSB:B1_ANG_LSB];
            bcast_d = (in_addr != MODULE_ID);
            timer_d = '0;
            state_d = ST_WAIT_LO;
          end
        end
      end
      ST_WAIT_LO: begin
        // A byte landing on the final timeout cycle still completes the frame.
        if (in_valid) begin
          if (in_byte.par) begin
            nak_hit = 1'b1;
          end else begin
            lo_d    = in_byte.data;
            state_d = ST_CHECK;
          end
        end else if (timer_q == TMR_LAST) begin
          nak_hit  = 1'b1;
          nak_code = NAK_TIMEOUT;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      ST_CHECK: begin
        if (frame_val > ANGLE_MAX) begin
          nak_hit  = 1'b1;
          nak_code = NAK_RANGE;
        end else begin
          state_d = ST_APPLY;
        end
      end
      ST_APPLY: begin
        angle_d      = frame_val;
        angle_load_d = 1'b1;
        link_err_d   = 1'b0;
        if (bcast_q) begin
          state_d = ST_IDLE;
        end else begin
          req_d   = 1'b1;
          reply_d = {ACK_HI, MODULE_ID};
          state_d = ST_REPLY;
        end
      end
      ST_REPLY: begin
        if (reply_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Every NAK drops the partial frame; broadcast errors are silent.
    if (nak_hit) begin
      if (nak_bc) begin
        state_d = ST_IDLE;
      end else begin
        req_d   = 1'b1;
        reply_d = {NAK_HI, nak_code};
        state_d = ST_REPLY;
      end
    end
    if (nak_hit || ovw_err) link_err_d = 1'b1;
    err_cnt_d = sat_add8(err_cnt_q, {1'b0, nak_hit} + {1'b0, ovw_err});
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_prev_q    <= 1'b0;
      evt_q        <= 1'b0;
      hold_full_q  <= 1'b0;
      state_q      <= ST_IDLE;
      timer_q      <= '0;
      bcast_q      <= 1'b0;
      angle_q      <= 12'd0;
      angle_load_q <= 1'b0;
      err_cnt_q    <= 8'd0;
      link_err_q   <= 1'b0;
      req_q        <= 1'b0;
    end else begin
      rx_prev_q    <= rx_prev_d;
      evt_q        <= evt_d;
      hold_full_q  <= hold_full_d;
      state_q      <= state_d;
      timer_q      <= timer_d;
      bcast_q      <= bcast_d;
      angle_q      <= angle_d;
      angle_load_q <= angle_load_d;
      err_cnt_q    <= err_cnt_d;
      link_err_q   <= link_err_d;
      req_q        <= req_d;
    end
  end

  // Payload registers are qualified by the control flops above.
  always_ff @(posedge clk) begin
    evt_byte_q <= evt_byte_d;
    hold_q     <= hold_d;
    hi_q       <= hi_d;
    lo_q       <= lo_d;
    reply_q    <= reply_d;
  end

  angle_cmd_ctrl_reply_sender u_reply_sender (
    .clk        (clk),
    .reset      (reset),
    .req        (req_q),
    .req_byte   (reply_q),
    .tx_busy    (tx_busy),
    .data_to_tx (data_to_tx),
    .start_tx   (start_tx),
    .done       (reply_done)
  );

  assign angle      = angle_q;
  assign angle_load = angle_load_q;
  assign err_cnt    = err_cnt_q;
  assign link_err   = link_err_q;

endmodule

// File: tb/tb_angle_cmd_ctrl.sv
// Bench for angle_cmd_ctrl: vector table, randomized frames against a
// frame-level model, and directed multi-cycle corner sequences.
module tb_angle_cmd_ctrl;

  localparam int TB_TIMEOUT = 400;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  data_received;
  logic        rx_done;
  logic        parity_error;
  logic        tx_busy;
  logic [7:0]  data_to_tx;
  logic        start_tx;
  logic [11:0] angle;
  logic        angle_load;
  logic [7:0]  err_cnt;
  logic        link_err;

  int total = 0;
  int bad = 0;
  int tx_len = 3;
  bit tx_block = 1'b0;
  logic [7:0] tx_log[$];
  int load_cnt = 0;
  int load_run = 0;
  int load_max = 0;

  int m_angle;
  int m_err;
  bit m_link;

  typedef struct {
    logic [7:0] b1;
    bit         p1;
    bit         s2;
    logic [7:0] b2;
    bit         p2;
    int         etx;
    int         eang;
    int         eerr;
    bit         elink;
    int         eload;
  } vec_t;

  vec_t vt[13];

  always #5 clk = ~clk;

  angle_cmd_ctrl #(
    .MODULE_ID      (4'd1),
    .BCAST_ID       (4'hF),
    .ANGLE_MAX      (12'd3599),
    .TIMEOUT_CYCLES (TB_TIMEOUT)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .data_received (data_received),
    .rx_done       (rx_done),
    .parity_error  (parity_error),
    .tx_busy       (tx_busy),
    .data_to_tx    (data_to_tx),
    .start_tx      (start_tx),
    .angle         (angle),
    .angle_load    (angle_load),
    .err_cnt       (err_cnt),
    .link_err      (link_err)
  );

  // uart_tx stand-in: accepts a request, logs the byte, stays busy tx_len clocks.
  initial begin
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (start_tx && !tx_busy && !tx_block && !reset) begin
        tx_log.push_back(data_to_tx);
        tx_busy = 1'b1;
        repeat (tx_len) @(negedge clk);
        tx_busy = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (angle_load === 1'b1) begin
        load_run++;
        if (load_run == 1) load_cnt++;
      end else begin
        load_run = 0;
      end
      if (load_run > load_max) load_max = load_run;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_now(input logic [7:0] b, input bit par, input int hold);
    data_received = b;
    parity_error  = par;
    rx_done       = 1'b1;
    repeat (hold) @(negedge clk);
    rx_done      = 1'b0;
    parity_error = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit par, input int hold);
    @(negedge clk);
    send_now(b, par, hold);
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic run_frame(input string tag, input logic [7:0] b1, input bit p1, input bit s2,
                           input logic [7:0] b2, input bit p2, input int etx, input int eang,
                           input int eerr, input bit elink, input int eload);
    int n0;
    int l0;
    n0 = tx_log.size();
    l0 = load_cnt;
    send_byte(b1, p1, 1);
    if (s2) send_byte(b2, p2, 1);
    settle(40);
    if (etx < 0) begin
      chk({tag, " tx count"}, tx_log.size() - n0, 0);
    end else begin
      chk({tag, " tx count"}, tx_log.size() - n0, 1);
      if (tx_log.size() > n0) chk({tag, " tx byte"}, tx_log[n0], etx);
    end
    chk({tag, " angle"}, angle, eang);
    chk({tag, " err_cnt"}, err_cnt, eerr);
    chk({tag, " link_err"}, link_err, elink);
    chk({tag, " loads"}, load_cnt - l0, eload);
  endtask

  // Frame-level reference: decides the outcome of a frame from the protocol rules.
  task automatic model_frame(input logic [7:0] b1, input bit p1, input logic [7:0] b2, input bit p2,
                             output bit s2, output int etx, output int eload);
    int addr;
    int val;
    bit bc;
    addr  = b1 / 16;
    val   = (b1 % 16) * 256 + b2;
    bc    = (addr == 15);
    s2    = 1'b0;
    etx   = -1;
    eload = 0;
    if (p1) begin
      etx = 'hE1;
      if (m_err < 255) m_err++;
      m_link = 1'b1;
    end else if (addr == 1 || addr == 15) begin
      s2 = 1'b1;
      if (p2 || val > 3599) begin
        if (!bc) etx = p2 ? 'hE1 : 'hE3;
        if (m_err < 255) m_err++;
        m_link = 1'b1;
      end else begin
        m_angle = val;
        m_link  = 1'b0;
        eload   = 1;
        if (!bc) etx = 'hA1;
      end
    end
  endtask

  initial begin
    int n0;
    int e0;
    int w;
    bit s2;
    int etx;
    int eload;
    int r;
    logic [3:0] addr;
    logic [11:0] ang;
    bit p1;
    bit p2;
    logic [7:0] b1;

    vt[0]  = '{8'h1E, 1'b0, 1'b1, 8'h0F, 1'b0, 'hA1, 3599, 0, 1'b0, 1};
    vt[1]  = '{8'h1F, 1'b0, 1'b1, 8'hFF, 1'b0, 'hE3, 3599, 1, 1'b1, 0};
    vt[2]  = '{8'h10, 1'b0, 1'b1, 8'h64, 1'b0, 'hA1, 100,  1, 1'b0, 1};
    vt[3]  = '{8'h13, 1'b1, 1'b0, 8'h00, 1'b0, 'hE1, 100,  2, 1'b1, 0};
    vt[4]  = '{8'h25, 1'b0, 1'b0, 8'h00, 1'b0, -1,   100,  2, 1'b1, 0};
    vt[5]  = '{8'hF0, 1'b0, 1'b1, 8'hC8, 1'b0, -1,   200,  2, 1'b0, 1};
    vt[6]  = '{8'h1E, 1'b0, 1'b1, 8'h10, 1'b0, 'hE3, 200,  3, 1'b1, 0};
    vt[7]  = '{8'h11, 1'b0, 1'b1, 8'h2C, 1'b0, 'hA1, 300,  3, 1'b0, 1};
    vt[8]  = '{8'h10, 1'b0, 1'b1, 8'h55, 1'b1, 'hE1, 300,  4, 1'b1, 0};
    vt[9]  = '{8'hFF, 1'b0, 1'b1, 8'hFF, 1'b0, -1,   300,  5, 1'b1, 0};
    vt[10] = '{8'h10, 1'b0, 1'b1, 8'h00, 1'b0, 'hA1, 0,    5, 1'b0, 1};
    vt[11] = '{8'hF0, 1'b0, 1'b1, 8'h11, 1'b1, -1,   0,    6, 1'b1, 0};
    vt[12] = '{8'h1E, 1'b0, 1'b1, 8'h0F, 1'b0, 'hA1, 3599, 6, 1'b0, 1};

    reset         = 1'b1;
    rx_done       = 1'b0;
    data_received = 8'h00;
    parity_error  = 1'b0;
    settle(3);
    chk("reset angle", angle, 0);
    chk("reset err_cnt", err_cnt, 0);
    chk("reset link_err", link_err, 0);
    chk("reset start_tx", start_tx, 0);
    chk("reset data_to_tx", data_to_tx, 0);
    chk("reset angle_load", angle_load, 0);
    reset = 1'b0;
    settle(3);

    for (int i = 0; i < 13; i++)
      run_frame($sformatf("vec%0d", i), vt[i].b1, vt[i].p1, vt[i].s2, vt[i].b2, vt[i].p2,
                vt[i].etx, vt[i].eang, vt[i].eerr, vt[i].elink, vt[i].eload);

    m_angle = vt[12].eang;
    m_err   = vt[12].eerr;
    m_link  = vt[12].elink;
    for (int i = 0; i < 80; i++) begin
      r = $urandom_range(0, 9);
      addr = (r < 5) ? 4'd1 : (r < 8) ? 4'hF : 4'($urandom_range(0, 15));
      r = $urandom_range(0, 9);
      ang = (r < 3) ? 12'(3598 + $urandom_range(0, 3)) : 12'($urandom_range(0, 4095));
      p1 = ($urandom_range(0, 9) == 0);
      p2 = ($urandom_range(0, 9) == 0);
      tx_len = $urandom_range(1, 6);
      b1 = {addr, ang[11:8]};
      model_frame(b1, p1, ang[7:0], p2, s2, etx, eload);
      run_frame($sformatf("rnd%0d", i), b1, p1, s2, ang[7:0], p2, etx, m_angle, m_err, m_link, eload);
    end

    // Bytes arriving while the reply is in flight are buffered.
    tx_len = 40;
    n0 = tx_log.size();
    e0 = err_cnt;
    send_byte(8'h10, 1'b0, 1);
    send_byte(8'h64, 1'b0, 1);
    settle(8);
    send_byte(8'h11, 1'b0, 1);
    settle(60);
    send_byte(8'h2C, 1'b0, 1);
    settle(60);
    chk("hold1 tx count", tx_log.size() - n0, 2);
    if (tx_log.size() >= n0 + 2) chk("hold1 second reply", tx_log[n0 + 1], 'hA1);
    chk("hold1 angle", angle, 300);
    chk("hold1 err_cnt", err_cnt, e0);

    n0 = tx_log.size();
    send_byte(8'h10, 1'b0, 1);
    send_byte(8'h64, 1'b0, 1);
    settle(8);
    send_byte(8'h1F, 1'b0, 1);
    settle(3);
    send_byte(8'h12, 1'b0, 1);
    settle(3);
    chk("hold2 overwrite err_cnt", err_cnt, e0 + 1);
    chk("hold2 overwrite link_err", link_err, 1);
    settle(60);
    send_byte(8'h34, 1'b0, 1);
    settle(60);
    chk("hold2 tx count", tx_log.size() - n0, 2);
    if (tx_log.size() >= n0 + 2) chk("hold2 second reply", tx_log[n0 + 1], 'hA1);
    chk("hold2 angle", angle, 12'h234);
    chk("hold2 err_cnt", err_cnt, e0 + 1);
    chk("hold2 link_err", link_err, 0);
    tx_len = 3;

    n0 = tx_log.size();
    e0 = err_cnt;
    send_byte(8'h12, 1'b0, 1);
    settle(TB_TIMEOUT + 40);
    chk("timeout tx count", tx_log.size() - n0, 1);
    if (tx_log.size() > n0) chk("timeout reply", tx_log[n0], 'hE2);
    chk("timeout err_cnt", err_cnt, e0 + 1);
    chk("timeout link_err", link_err, 1);
    chk("timeout angle", angle, 12'h234);

    n0 = tx_log.size();
    send_byte(8'h12, 1'b0, 1);
    settle(TB_TIMEOUT - 1);
    send_now(8'h9A, 1'b0, 1);
    settle(40);
    chk("last-cycle tx count", tx_log.size() - n0, 1);
    if (tx_log.size() > n0) chk("last-cycle reply", tx_log[n0], 'hA1);
    chk("last-cycle angle", angle, 12'h29A);
    chk("last-cycle err_cnt", err_cnt, e0 + 1);

    n0 = tx_log.size();
    send_byte(8'h13, 1'b0, 1);
    settle(TB_TIMEOUT);
    send_now(8'h9A, 1'b0, 1);
    settle(40);
    chk("late-byte tx count", tx_log.size() - n0, 1);
    if (tx_log.size() > n0) chk("late-byte reply", tx_log[n0], 'hE2);
    chk("late-byte angle", angle, 12'h29A);
    chk("late-byte err_cnt", err_cnt, e0 + 2);

    n0 = tx_log.size();
    e0 = err_cnt;
    w = load_cnt;
    send_byte(8'h10, 1'b0, 3);
    send_byte(8'h05, 1'b0, 2);
    settle(40);
    chk("long strobe tx count", tx_log.size() - n0, 1);
    chk("long strobe angle", angle, 5);
    chk("long strobe err_cnt", err_cnt, e0);
    chk("long strobe loads", load_cnt - w, 1);

    send_byte(8'h1E, 1'b0, 1);
    settle(3);
    #2 reset = 1'b1;
    #1;
    chk("reset WAIT_LO angle", angle, 0);
    chk("reset WAIT_LO err_cnt", err_cnt, 0);
    chk("reset WAIT_LO link_err", link_err, 0);
    chk("reset WAIT_LO start_tx", start_tx, 0);
    @(negedge clk);
    reset = 1'b0;
    settle(3);
    n0 = tx_log.size();
    send_byte(8'h0F, 1'b0, 1);
    settle(40);
    chk("post-reset stray byte tx", tx_log.size() - n0, 0);
    chk("post-reset stray byte angle", angle, 0);

    tx_block = 1'b1;
    send_byte(8'h10, 1'b0, 1);
    send_byte(8'h64, 1'b0, 1);
    w = 0;
    while (!start_tx && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("reply start_tx raised", start_tx, 1);
    chk("reply data", data_to_tx, 'hA1);
    settle(3);
    chk("reply start_tx held", start_tx, 1);
    chk("reply data stable", data_to_tx, 'hA1);
    #2 reset = 1'b1;
    #1;
    chk("reset in reply start_tx", start_tx, 0);
    chk("reset in reply data_to_tx", data_to_tx, 0);
    chk("reset in reply angle", angle, 0);
    @(negedge clk);
    reset = 1'b0;
    tx_block = 1'b0;
    settle(3);

    tx_len = 2;
    for (int i = 0; i < 200; i++) begin
      send_byte(8'h13, 1'b1, 1);
      settle(10);
    end
    settle(20);
    chk("err_cnt after 200", err_cnt, 200);
    for (int i = 0; i < 100; i++) begin
      send_byte(8'h13, 1'b1, 1);
      settle(10);
    end
    settle(30);
    chk("err_cnt saturated", err_cnt, 255);
    chk("link_err after errors", link_err, 1);
    chk("angle_load width", load_max, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/angle_cmd_ctrl.md
Name: angle_cmd_ctrl

Overview:
- Sequences the UART-to-modulator command path: assembles two received bytes into a 12-bit angle command, checks module address, parity and range, and loads the modulator angle register.
- Sends a one-byte ACK/NAK reply through the UART TX.
- Sits between uart_rx/uart_tx and the modulator in the FPGA top.
- Adds an inter-byte timeout and parity/range error recovery.

Parameters:
- MODULE_ID, 4'd1, this board's address; matched against the command byte-1 upper nibble.
- BCAST_ID, 4'hF, broadcast address; accepted, but no reply is sent.
- ANGLE_MAX, 12'd3599, largest legal angle; larger values are NAKed.
- TIMEOUT_CYCLES, 48000, clk cycles allowed between byte 1 and byte 2 (1 ms at 48 MHz).

Ports:
- clk  in  1  system clock (48 MHz HFOSC).
- reset  in  1  asynchronous, active-high reset.
- data_received  in  8  byte from uart_rx.
- rx_done  in  1  uart_rx byte strobe; may last several clk cycles.
- parity_error  in  1  parity flag, qualified by rx_done.
- tx_busy  in  1  uart_tx busy.
- data_to_tx  out  8  reply byte.
- start_tx  out  1  TX request.
- angle  out  12  current modulator angle.
- angle_load  out  1  one-cycle pulse when angle updates.
- err_cnt  out  8  saturating error count.
- link_err  out  1  sticky; set on any error, cleared by the next good frame.

Behaviour:
- Reset, asynchronous: state=IDLE, angle=0, angle_load=0, start_tx=0, data_to_tx=0, err_cnt=0, link_err=0, holding register empty, timeout counter=0.
- rx_done edge detection: registered, acted on at the rising edge only, so one byte = one event. Latency from edge to action is 1 clk.
- Frame format:
  - byte1 = {addr[3:0], angle[11:8]}
  - byte2 = angle[7:0]
- Replies:
  - ACK = {4'hA, MODULE_ID}
  - NAK = {4'hE, code}; code 1=parity, 2=timeout, 3=range.
- States:
  - IDLE: on rx event:
    - parity error -> NAK1.
    - addr not MODULE_ID and not BCAST_ID -> stay IDLE, no count.
    - otherwise latch byte1 -> WAIT_LO, clear timer.
  - WAIT_LO: timer increments each clk.
    - Timer reaches TIMEOUT_CYCLES-1 with no event -> NAK2.
    - rx event with parity error -> NAK1.
    - Good rx event -> latch byte2 -> CHECK.
    - If the rx event and the final timeout cycle coincide, the byte wins.
  - CHECK (1 clk):
    - {hi[3:0], lo} > ANGLE_MAX -> NAK3.
    - Otherwise -> APPLY.
  - APPLY (1 clk): angle <= value, angle_load=1, link_err=0. Then go to REPLY with ACK, or to IDLE if broadcast.
  - REPLY: wait for tx_busy=0, drive data_to_tx, assert start_tx, and hold it until tx_busy=1 is sampled -> TX_WAIT.
  - TX_WAIT: on tx_busy=0 -> IDLE, or process the holding register first if it is full.
- NAK path: err_cnt += 1, saturating at 255; link_err=1. Broadcast errors are counted but get no reply. Any NAK discards the partial frame.
- Angle is committed only after the full frame passes every check; a bad frame never disturbs the modulator.
- rx event during REPLY/TX_WAIT:
  - Stored in a 1-deep holding register with its parity flag.
  - A second event while the register is full overwrites it and counts one error. No NAK is sent for the overwrite.
- Reset mid-frame or mid-reply: immediate return to reset values. start_tx drops asynchronously.
- data_to_tx is stable while start_tx=1.

Decomposition:
- Shared package/header:
  - State encodings.
  - Reply constants: ACK_HI=4'hA, NAK_HI=4'hE, NAK codes 1/2/3.
  - Frame field positions.
  - BCAST_ID default.
- Sub-module: reply_sender, which owns the REPLY/TX_WAIT handshake with uart_tx. It has a req/byte input and a done output. The main FSM stays framing-only.

Test Plan:
- Frame 0x1E, 0x0F from MODULE_ID=1 -> angle=0xE0F=3599, angle_load pulses once for 1 clk, TX sends 0xA1, err_cnt=0.
- Byte 0x1F, 0xFF (angle 4095 > 3599) -> angle unchanged, TX sends 0xE3, err_cnt=1, link_err=1; then a good frame clears link_err.
- Byte1=0x12 then silence for 48000 clk -> TX sends 0xE2, FSM returns to IDLE; a byte arriving at exactly cycle 47999 is accepted instead.
- Byte1 with parity_error=1 -> TX sends 0xE1; frame 0x2x (addr 2) -> ignored, no reply, err_cnt unchanged; broadcast 0xF0, 0x64 -> angle=100, no TX.
- New byte1 arriving while tx_busy=1 -> buffered, then processed after the reply; two extra bytes -> err_cnt +1, last byte kept.
- rx_done held for 2 clk -> exactly one byte consumed; reset asserted in WAIT_LO and during start_tx -> all outputs return to 0 asynchronously; err_cnt saturates at 255 after 300 errors.
